uart_arbiter: RTL and testbench
===============================

Name: uart_arbiter

Overview:
- Shares the single UART byte-buffer port pair (read pulse/done, write pulse/done) among NREQ requesters, e.g. the core load/store unit, the boot loader and the debug monitor.
- Read and write directions are arbitrated independently, each with its own FSM.
- Each requester may have at most one outstanding operation per direction.
- Sits between the requesters and the UART buffer, on the same clock.

Parameters:
NREQ, 2, number of requesters (legal range 2..8); grant index width IW = $clog2(NREQ)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req_renable  input  NREQ  per-requester one-cycle read request pulse
req_rdone  output  NREQ  per-requester one-cycle read completion pulse
req_rdata  output  32  read data, shared by all requesters; valid with any req_rdone bit
req_wenable  input  NREQ  per-requester one-cycle write request pulse
req_wdata  input  32*NREQ  flattened write data; requester i uses bits [32*i +: 32], low byte significant
req_wdone  output  NREQ  per-requester one-cycle write completion pulse
buf_renable  output  1  read pulse to UART buffer
buf_rdone  input  1  read completion pulse from UART buffer
buf_rdata  input  32  read data from UART buffer
buf_wenable  output  1  write pulse to UART buffer
buf_wdone  input  1  write completion pulse from UART buffer
buf_wdata  output  32  write data to UART buffer

Behaviour:
- Reset (rst=1, async): every output 0; all pending bits 0; round-robin pointers 0; both FSMs in IDLE; captured write data 0.
- Reset mid-operation abandons the transaction without any done pulse. The UART buffer must be reset by the same event.
- Pending capture (per direction):
  - req_renable[i]=1 sets rpend[i] at the clock edge.
  - req_wenable[i]=1 sets wpend[i] and captures req_wdata slice i into wdata_q[i].
  - A request pulse while that bit is already pending is ignored: the original request and data are kept. This is a protocol violation and is flagged by a bench assertion.
  - A pulse in cycle t is first visible to arbitration in cycle t+1.
- Read FSM states: R_IDLE, R_WAIT.
  - R_IDLE with rpend != 0: pick rgrant as the first pending index at or after rptr, wrapping modulo NREQ. buf_renable=1 for exactly one cycle; go to R_WAIT.
  - R_WAIT: buf_renable=0. On buf_rdone: req_rdata<=buf_rdata, req_rdone[rgrant]=1 for one cycle, clear rpend[rgrant], rptr<=(rgrant+1) mod NREQ, go to R_IDLE.
  - buf_rdone seen in R_IDLE is ignored.
  - req_rdata holds its last value between completions.
- Write FSM states: W_IDLE, W_WAIT. Identical structure, using wpend, wptr, buf_wenable, buf_wdone, req_wdone.
  - buf_wdata<=wdata_q[wgrant] in the same cycle buf_wenable is raised.
  - buf_wdata stays stable through W_WAIT.
- Latency: request pulse at cycle t gives buf_enable at t+1, earliest buffer done at t+2, requester done at t+3.
- Peak rate: one operation per direction every 3 cycles. The FSM always passes through IDLE after a done.
- A requester's done pulse and a new request pulse from that requester may coincide. The new request is captured, because the clear of the completed request and the set of the new one both apply and set wins.
- Buffer stalls (full or empty) simply lengthen WAIT. There is no timeout.
- Read and write paths share no state and may complete in the same cycle.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIO_EN.
- Defined: both directions use fixed priority, lowest pending index wins; rptr and wptr are not implemented.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Single read, req_renable[0] pulsed at cycle 0, buffer returns 0x41 one cycle after buf_renable: buf_renable high at cycle 1 only, req_rdone=2'b01 at cycle 3, req_rdata=0x41.
- req_renable=2'b11 in the same cycle, buffer returns 0x10 then 0x20: req_rdone[0] with 0x10 first, then req_rdone[1] with 0x20; exactly two buf_renable pulses.
- Both requesters re-request reads immediately after each done, 8 transactions:
  - Default build: grant order 0,1,0,1,...
  - With UART_ARB_FIXED_PRIO_EN: requester 0 served every time while it stays pending.
- req_wenable[1] pulsed with wdata slice 1 = 0x55, slice changed to 0xAA the next cycle, buf_wdone delayed 20 cycles: buf_wdata=0x55 for the whole transaction; req_wdone=2'b10 one cycle after buf_wdone.
- Read from requester 0 and write from requester 1 issued in the same cycle: both buf enables pulse at cycle 1, both done pulses at cycle 3.
- rst asserted mid-cycle during R_WAIT: all outputs 0 before the next clock edge; no req_rdone ever issued for that request; after rst deasserts, a fresh read completes normally.

Source files
------------

// File: rtl/uart_arbiter.sv
// uart_arbiter: shares one UART byte-buffer read/write port pair among NREQ requesters.
// Read and write are arbitrated independently; define UART_ARB_FIXED_PRIO_EN for fixed priority.
module uart_arbiter #(
  parameter int NREQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_renable,
  output logic [NREQ-1:0]    req_rdone,
  output logic [31:0]        req_rdata,
  input  logic [NREQ-1:0]    req_wenable,
  input  logic [32*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]    req_wdone,
  output logic               buf_renable,
  input  logic               buf_rdone,
  input  logic [31:0]        buf_rdata,
  output logic               buf_wenable,
  input  logic               buf_wdone,
  output logic [31:0]        buf_wdata
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {R_IDLE, R_WAIT} rstate_t;
  typedef enum logic {W_IDLE, W_WAIT} wstate_t;

  rstate_t         r_rstate;
  wstate_t         r_wstate;
  logic [NREQ-1:0] r_rpend;
  logic [NREQ-1:0] r_wpend;
  logic [31:0]     r_wdata_q [NREQ];
  logic [IW-1:0]   r_rgrant;
  logic [IW-1:0]   r_wgrant;
  logic [IW-1:0]   w_rptr;
  logic [IW-1:0]   w_wptr;
  logic [IW-1:0]   w_rpick;
  logic [IW-1:0]   w_wpick;
  logic [NREQ-1:0] w_rclr;
  logic [NREQ-1:0] w_wclr;

  // First set bit of pend at or after ptr, wrapping modulo NREQ.
  function automatic logic [IW-1:0] f_pick(input logic [NREQ-1:0] pend, input logic [IW-1:0] ptr);
    logic [2*NREQ-1:0] rot;
    logic              found;
    int                s;
    f_pick = '0;
    found  = 1'b0;
    s      = 0;
    rot    = {pend, pend} >> ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        s = int'(ptr) + k;
        if (s >= NREQ) s = s - NREQ;
        f_pick = IW'(s);
      end
    end
  endfunction

  function automatic logic [IW-1:0] f_next(input logic [IW-1:0] g);
    f_next = (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
  endfunction

`ifdef UART_ARB_FIXED_PRIO_EN
  assign w_rptr = '0;
  assign w_wptr = '0;
`else
  logic [IW-1:0] r_rptr;
  logic [IW-1:0] r_wptr;

  assign w_rptr = r_rptr;
  assign w_wptr = r_wptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else begin
      if (r_rstate == R_WAIT && buf_rdone) r_rptr <= f_next(r_rgrant);
      if (r_wstate == W_WAIT && buf_wdone) r_wptr <= f_next(r_wgrant);
    end
  end
`endif

  assign w_rpick = f_pick(r_rpend, w_rptr);
  assign w_wpick = f_pick(r_wpend, w_wptr);

  always_comb begin
    w_rclr = '0;
    w_wclr = '0;
    if (r_rstate == R_WAIT && buf_rdone) w_rclr[r_rgrant] = 1'b1;
    if (r_wstate == W_WAIT && buf_wdone) w_wclr[r_wgrant] = 1'b1;
  end

  // Set wins over clear, so a re-request coinciding with its own completion is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rpend <= '0;
      r_wpend <= '0;
      for (int i = 0; i < NREQ; i++) r_wdata_q[i] <= '0;
    end else begin
      r_rpend <= (r_rpend & ~w_rclr) | req_renable;
      r_wpend <= (r_wpend & ~w_wclr) | req_wenable;
      for (int i = 0; i < NREQ; i++) begin
        if (req_wenable[i] && (!r_wpend[i] || w_wclr[i])) r_wdata_q[i] <= req_wdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate    <= R_IDLE;
      r_rgrant    <= '0;
      buf_renable <= 1'b0;
      req_rdone   <= '0;
      req_rdata   <= '0;
    end else begin
      buf_renable <= 1'b0;
      req_rdone   <= w_rclr;
      case (r_rstate)
        R_IDLE: begin
          if (|r_rpend) begin
            r_rgrant    <= w_rpick;
            buf_renable <= 1'b1;
            r_rstate    <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (buf_rdone) begin
            req_rdata <= buf_rdata;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate    <= W_IDLE;
      r_wgrant    <= '0;
      buf_wenable <= 1'b0;
      buf_wdata   <= '0;
      req_wdone   <= '0;
    end else begin
      buf_wenable <= 1'b0;
      req_wdone   <= w_wclr;
      case (r_wstate)
        W_IDLE: begin
          if (|r_wpend) begin
            r_wgrant    <= w_wpick;
            buf_wdata   <= r_wdata_q[w_wpick];
            buf_wenable <= 1'b1;
            r_wstate    <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (buf_wdone) r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_arbiter.sv
// Bench for uart_arbiter: vector table, directed corner sequences, randomized run against a model.
`timescale 1ns/1ps
module tb_uart_arbiter;
  localparam int NREQ = 2;
`ifdef UART_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_renable, req_rdone, req_wenable, req_wdone;
  logic [31:0]        req_rdata, buf_rdata, buf_wdata;
  logic [32*NREQ-1:0] req_wdata;
  logic               buf_renable, buf_rdone, buf_wenable, buf_wdone;

  int checks = 0;
  int failures = 0;
  int ecnt = 0;

  always #5 clk = ~clk;

  uart_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_renable(req_renable), .req_rdone(req_rdone), .req_rdata(req_rdata),
    .req_wenable(req_wenable), .req_wdata(req_wdata), .req_wdone(req_wdone),
    .buf_renable(buf_renable), .buf_rdone(buf_rdone), .buf_rdata(buf_rdata),
    .buf_wenable(buf_wenable), .buf_wdone(buf_wdone), .buf_wdata(buf_wdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // ---------------- UART buffer model ----------------
  int          rcnt = -1, wcnt = -1, rlat = 1, wlat = 1;
  bit          lat_rand = 1'b0;
  logic [31:0] rd_q[$];
  logic        rfire, wfire, wstable;
  logic [31:0] wcap;

  task automatic tick();
    @(posedge clk); #1;
    ecnt++;
    rfire = 1'b0; wfire = 1'b0; buf_rdone = 1'b0; buf_wdone = 1'b0;
    if (rst) begin
      rcnt = -1; wcnt = -1;
    end else begin
      if (rcnt > 0) rcnt--;
      if (rcnt == 0) begin
        buf_rdone = 1'b1; rfire = 1'b1; rcnt = -1;
        if (rd_q.size() > 0) buf_rdata = rd_q.pop_front();
        else buf_rdata = $urandom;
      end
      if (wcnt >= 0 && buf_wdata !== wcap) wstable = 1'b0;
      if (wcnt > 0) wcnt--;
      if (wcnt == 0) begin
        buf_wdone = 1'b1; wfire = 1'b1; wcnt = -1;
        chk("buf_wdata_stable", wstable, 1'b1);
      end
      if (buf_renable) begin
        chk("buf_renable_while_busy", rcnt >= 0, 1'b0);
        rcnt = lat_rand ? int'($urandom_range(1, 5)) : rlat;
      end
      if (buf_wenable) begin
        chk("buf_wenable_while_busy", wcnt >= 0, 1'b0);
        wcnt = lat_rand ? int'($urandom_range(1, 5)) : wlat;
        wcap = buf_wdata; wstable = 1'b1;
      end
    end
  endtask

  // ---------------- reference model ----------------
  int          out_t [2][NREQ];   // edge at which the request is sampled, -1 when free
  logic [31:0] mwd [NREQ];
  int          mptr [2], mbusy [2], mready [2], exp_due [2], exp_g [2];
  logic [31:0] exp_d [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NREQ; i++) out_t[d][i] = -1;
      mptr[d] = 0; mbusy[d] = -1; mready[d] = 0; exp_due[d] = -1; exp_g[d] = 0;
    end
  endtask

  task automatic pulse_req(input int d, input int i);
    logic [31:0] v;
    v = $urandom;
    assert (out_t[d][i] < 0) else $error("protocol violation: request from %0d while pending", i);
    if (d == 0) req_renable[i] = 1'b1;
    else begin
      req_wenable[i] = 1'b1; req_wdata[32*i +: 32] = v; mwd[i] = v;
    end
    out_t[d][i] = ecnt + 1;
  endtask

  // pol 0: random requests, 1: served reader re-requests as its buffer read completes, 2: none
  task automatic model_step(input int pol);
    logic            en, fire;
    logic [NREQ-1:0] act, expv;
    int              g, i, fg;
    string           nm;
    fg = -1;
    for (int d = 0; d < 2; d++) begin
      en = (d == 1) ? buf_wenable : buf_renable;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        i = (mptr[d] + k) % NREQ;
        if (g < 0 && out_t[d][i] >= 0 && out_t[d][i] < ecnt) g = i;
      end
      if (d == 1) nm = "buf_wenable"; else nm = "buf_renable";
      chk(nm, en, (mbusy[d] < 0 && ecnt >= mready[d] && g >= 0));
      if (en && mbusy[d] < 0 && g >= 0) begin
        mbusy[d] = g;
        if (d == 1) chk("buf_wdata_grant", buf_wdata, mwd[g]);
      end
      fire = (d == 1) ? wfire : rfire;
      if (fire && mbusy[d] >= 0) begin
        exp_due[d] = ecnt + 1; exp_g[d] = mbusy[d]; exp_d[d] = buf_rdata;
        out_t[d][mbusy[d]] = -1;
        mptr[d] = FIXED ? 0 : (mbusy[d] + 1) % NREQ;
        mready[d] = ecnt + 2;
        if (d == 0) fg = mbusy[d];
        mbusy[d] = -1;
      end
      act = (d == 1) ? req_wdone : req_rdone;
      expv = '0;
      if (exp_due[d] == ecnt) expv[exp_g[d]] = 1'b1;
      if (d == 1) nm = "req_wdone"; else nm = "req_rdone";
      chk(nm, act, expv);
      if (exp_due[d] == ecnt) begin
        if (d == 0) chk("req_rdata", req_rdata, exp_d[0]);
        exp_due[d] = -1;
      end
    end
    req_renable = '0; req_wenable = '0;
    for (int j = 0; j < NREQ; j++) req_wdata[32*j +: 32] = $urandom;
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (pol == 0 && out_t[d][j] < 0 && $urandom_range(0, 3) == 0) pulse_req(d, j);
        else if (pol == 1 && d == 0 && j == fg) pulse_req(0, j);
      end
    end
  endtask

  task automatic outs_zero(input string name);
    chk({name, "_ctl"}, {req_rdone, req_wdone, buf_renable, buf_wenable}, '0);
    chk({name, "_dat"}, {req_rdata, buf_wdata}, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_renable = '0; req_wenable = '0; req_wdata = '0;
    #1;
    outs_zero("reset");
    tick(); tick();
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NREQ-1:0] ren, wen;
    logic [31:0]     wd1;
    logic            ben_r, ben_w;
    logic [NREQ-1:0] rdone, wdone;
    logic [31:0]     rdata, bwdata;
  } vec_t;

  function automatic vec_t mk(logic [1:0] ren, logic [1:0] wen, logic [31:0] wd1, logic br, logic bw,
                              logic [1:0] rd, logic [1:0] wd, logic [31:0] rdat, logic [31:0] bwd);
    vec_t v;
    v.ren = ren; v.wen = wen; v.wd1 = wd1; v.ben_r = br; v.ben_w = bw;
    v.rdone = rd; v.wdone = wd; v.rdata = rdat; v.bwdata = bwd;
    return v;
  endfunction

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt [10];
    int          n, nren, st, en_e, fire_e, done_e, bad, seen, got;
    logic [1:0]  donev;
    logic [1:0]  dlog [$];
    logic [31:0] rlog [$];

    rst = 1'b0; req_renable = '0; req_wenable = '0; req_wdata = '0;
    buf_rdone = 1'b0; buf_wdone = 1'b0; buf_rdata = '0;
    #2;
    do_reset();

    // single read, then read0 + write1 in the same cycle
    vt[0] = mk(2'b01, 2'b00, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0,  32'h0);
    vt[1] = mk(2'b00, 2'b00, 32'h0,        1, 0, 2'b00, 2'b00, 32'h0,  32'h0);
    vt[2] = mk(2'b00, 2'b00, 32'h0,        0, 0, 2'b00, 2'b00, 32'h0,  32'h0);
    vt[3] = mk(2'b00, 2'b00, 32'h0,        0, 0, 2'b01, 2'b00, 32'h41, 32'h0);
    vt[4] = mk(2'b00, 2'b00, 32'h0,        0, 0, 2'b00, 2'b00, 32'h41, 32'h0);
    vt[5] = mk(2'b01, 2'b10, 32'h12345678, 0, 0, 2'b00, 2'b00, 32'h41, 32'h0);
    vt[6] = mk(2'b00, 2'b00, 32'h0,        1, 1, 2'b00, 2'b00, 32'h41, 32'h12345678);
    vt[7] = mk(2'b00, 2'b00, 32'h0,        0, 0, 2'b00, 2'b00, 32'h41, 32'h12345678);
    vt[8] = mk(2'b00, 2'b00, 32'h0,        0, 0, 2'b01, 2'b10, 32'h99, 32'h12345678);
    vt[9] = mk(2'b00, 2'b00, 32'h0,        0, 0, 2'b00, 2'b00, 32'h99, 32'h12345678);
    rd_q.push_back(32'h41); rd_q.push_back(32'h99);
    rlat = 1; wlat = 1; lat_rand = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_renable = vt[k].ren; req_wenable = vt[k].wen;
      req_wdata = {vt[k].wd1, 32'hDEAD0000};
      tick();
      chk($sformatf("vec%0d_buf_renable", k), buf_renable, vt[k].ben_r);
      chk($sformatf("vec%0d_buf_wenable", k), buf_wenable, vt[k].ben_w);
      chk($sformatf("vec%0d_req_rdone", k), req_rdone, vt[k].rdone);
      chk($sformatf("vec%0d_req_wdone", k), req_wdone, vt[k].wdone);
      chk($sformatf("vec%0d_req_rdata", k), req_rdata, vt[k].rdata);
      chk($sformatf("vec%0d_buf_wdata", k), buf_wdata, vt[k].bwdata);
    end

    // two simultaneous reads
    do_reset();
    rd_q.delete(); rd_q.push_back(32'h10); rd_q.push_back(32'h20);
    pulse_req(0, 0); pulse_req(0, 1);
    nren = 0;
    for (int k = 0; k < 20; k++) begin
      tick(); model_step(2);
      if (buf_renable) nren++;
      if (req_rdone != 0) begin dlog.push_back(req_rdone); rlog.push_back(req_rdata); end
    end
    chk("dual_renable_count", nren, 2);
    chk("dual_done_count", dlog.size(), 2);
    if (dlog.size() == 2) begin
      chk("dual_first_done", dlog[0], 2'b01);
      chk("dual_first_data", rlog[0], 32'h10);
      chk("dual_second_done", dlog[1], 2'b10);
      chk("dual_second_data", rlog[1], 32'h20);
    end

    // continuous re-requests: round-robin alternates, fixed priority keeps serving 0
    do_reset();
    dlog.delete();
    pulse_req(0, 0); pulse_req(0, 1);
    for (int k = 0; k < 100 && dlog.size() < 8; k++) begin
      tick(); model_step(1);
      if (req_rdone != 0) dlog.push_back(req_rdone);
    end
    chk("rerequest_count", dlog.size(), 8);
    for (int k = 0; k < dlog.size(); k++)
      chk($sformatf("rerequest_grant%0d", k), dlog[k], FIXED ? 2'b01 : ((k % 2 == 0) ? 2'b01 : 2'b10));

    // write data captured at request, held through a 20-cycle buffer stall
    do_reset();
    wlat = 20;
    req_wenable = 2'b10; req_wdata = {32'h55, 32'h0};
    tick();
    st = ecnt;
    req_wenable = '0; req_wdata = {32'hAA, 32'h0};
    en_e = -1; fire_e = -1; done_e = -1; bad = 0; donev = '0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (buf_wenable) en_e = ecnt;
      if (en_e >= 0 && done_e < 0 && buf_wdata !== 32'h55) bad++;
      if (wfire) fire_e = ecnt;
      if (req_wdone != 0) begin donev = req_wdone; done_e = ecnt; end
    end
    chk("wstall_enable_latency", en_e - st, 1);
    chk("wstall_buf_delay", fire_e - en_e, 20);
    chk("wstall_done_latency", done_e - fire_e, 1);
    chk("wstall_done_bits", donev, 2'b10);
    chk("wstall_wdata_held", bad, 0);
    wlat = 1;

    // reset while a read waits on the buffer
    do_reset();
    rd_q.delete(); rd_q.push_back(32'h77);
    req_renable = 2'b01; tick(); req_renable = '0;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_rst_rdata", req_rdata, 32'h77);
    rlat = 10;
    req_renable = 2'b01; tick(); req_renable = '0;
    tick(); tick();
    #2 rst = 1'b1;
    #1 outs_zero("mid_rst");
    tick(); tick();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (req_rdone != 0) seen++;
    end
    chk("no_done_after_rst", seen, 0);
    rlat = 1; rd_q.push_back(32'h5A);
    req_renable = 2'b01; tick(); req_renable = '0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (req_rdone == 2'b01 && req_rdata == 32'h5A) got++;
    end
    chk("post_rst_read", got, 1);

    // randomized traffic against the model, then drain
    do_reset();
    rd_q.delete();
    lat_rand = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      tick(); model_step(0);
    end
    for (int k = 0; k < 60; k++) begin
      tick(); model_step(2);
    end
    n = 0;
    for (int d = 0; d < 2; d++) begin
      if (mbusy[d] >= 0 || exp_due[d] >= 0) n++;
      for (int i = 0; i < NREQ; i++) if (out_t[d][i] >= 0) n++;
    end
    chk("random_drained", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
